// File: rtl/regbank32_if.sv
// rtl/regbank32_if.sv - write/read/dump-port bundle of the MIPS register bank
interface regbank32_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic [4:0]       wa;
  logic [WIDTH-1:0] wd;
  logic [4:0]       ra1;
  logic [4:0]       ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             dump_start;
  logic             dump_valid;
  logic             dump_ready;
  logic [4:0]       dump_idx;
  logic [WIDTH-1:0] dump_data;
  logic             dump_busy;
  logic             dump_done;

  modport master (
    output we, wa, wd, ra1, ra2, dump_start, dump_ready,
    input  rd1, rd2, dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, dump_start, dump_ready,
    output rd1, rd2, dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );
endinterface

// File: rtl/regbank32.sv
// rtl/regbank32.sv - 32xWIDTH register bank, 2 comb read ports, handshaked dump port
module regbank32 #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  regbank32_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] regs [32];
  logic [4:0]       idx_next;
  logic             accept;

  // r0 is reset like the others and never written, so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.we && bus.wa != 5'd0) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  always_comb begin
    bus.rd1 = regs[bus.ra1];
    if (BYPASS && bus.we && bus.wa == bus.ra1) bus.rd1 = bus.wd;
    if (bus.ra1 == 5'd0) bus.rd1 = '0;
  end

  always_comb begin
    bus.rd2 = regs[bus.ra2];
    if (BYPASS && bus.we && bus.wa == bus.ra2) bus.rd2 = bus.wd;
    if (bus.ra2 == 5'd0) bus.rd2 = '0;
  end

  assign accept   = (state == SEND) && bus.dump_ready;
  assign idx_next = bus.dump_idx + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.dump_start) state_next = SEND;
      SEND:    if (accept && bus.dump_idx == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat snapshot: data is loaded only on start or accept, so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dump_idx  <= 5'd0;
      bus.dump_data <= '0;
    end else if (state == IDLE && bus.dump_start) begin
      bus.dump_idx  <= 5'd0;
      bus.dump_data <= '0;
    end else if (accept && bus.dump_idx != 5'd31) begin
      bus.dump_idx  <= idx_next;
      bus.dump_data <= regs[idx_next];
    end
  end

  assign bus.dump_valid = (state == SEND);
  assign bus.dump_busy  = (state == SEND);
  assign bus.dump_done  = (state == DONE);

endmodule

// File: tb/tb_regbank32.sv
// tb/tb_regbank32.sv - self-checking bench for regbank32 (BYPASS=1 and BYPASS=0 instances)
module tb_regbank32;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regbank32_if #(.WIDTH(W)) bus1 ();
  regbank32_if #(.WIDTH(W)) bus0 ();

  regbank32 #(.WIDTH(W), .BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  regbank32 #(.WIDTH(W), .BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  assign bus0.we         = bus1.we;
  assign bus0.wa         = bus1.wa;
  assign bus0.wd         = bus1.wd;
  assign bus0.ra1        = bus1.ra1;
  assign bus0.ra2        = bus1.ra2;
  assign bus0.dump_start = bus1.dump_start;
  assign bus0.dump_ready = bus1.dump_ready;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register array plus a dump cursor with a snapshot of the presented beat
  logic [W-1:0] m_regs [32];
  bit           m_active;
  bit           m_done;
  int           m_idx;
  logic [W-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin : model
    bit was_done;
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_active = 1'b0;
      m_done   = 1'b0;
      m_idx    = 0;
      m_data   = '0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (m_active) begin
        if (bus1.dump_ready) begin
          if (m_idx == 31) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end else begin
            m_idx  = m_idx + 1;
            m_data = m_regs[m_idx];
          end
        end
      end else if (!was_done && bus1.dump_start) begin
        m_active = 1'b1;
        m_idx    = 0;
        m_data   = '0;
      end
      if (bus1.we && bus1.wa != 5'd0) m_regs[bus1.wa] = bus1.wd;
    end
  end

  function automatic logic [W-1:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return '0;
    if (byp && bus1.we && bus1.wa == a) return bus1.wd;
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    chk("rd1_bypass",   bus1.rd1, exp_rd(bus1.ra1, 1'b1));
    chk("rd2_bypass",   bus1.rd2, exp_rd(bus1.ra2, 1'b1));
    chk("rd1_nobypass", bus0.rd1, exp_rd(bus1.ra1, 1'b0));
    chk("rd2_nobypass", bus0.rd2, exp_rd(bus1.ra2, 1'b0));
    chk("dump_valid",   {31'd0, bus1.dump_valid}, {31'd0, m_active});
    chk("dump_busy",    {31'd0, bus1.dump_busy},  {31'd0, m_active});
    chk("dump_done",    {31'd0, bus1.dump_done},  {31'd0, m_done});
    chk("dump_valid_0", {31'd0, bus0.dump_valid}, {31'd0, m_active});
    chk("dump_done_0",  {31'd0, bus0.dump_done},  {31'd0, m_done});
    if (m_active) begin
      chk("dump_idx",    {27'd0, bus1.dump_idx}, m_idx);
      chk("dump_data",   bus1.dump_data, m_data);
      chk("dump_data_0", bus0.dump_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int beats;
  int done_at;

  initial begin
    bus1.we = 1'b0; bus1.wa = 5'd0; bus1.wd = '0;
    bus1.ra1 = 5'd5; bus1.ra2 = 5'd0;
    bus1.dump_start = 1'b0; bus1.dump_ready = 1'b0;

    #1 rst_n = 1'b0;
    #3;
    chk("rst_valid", {31'd0, bus1.dump_valid}, 32'd0);
    chk("rst_busy",  {31'd0, bus1.dump_busy},  32'd0);
    chk("rst_done",  {31'd0, bus1.dump_done},  32'd0);
    chk("rst_idx",   {27'd0, bus1.dump_idx},   32'd0);
    chk("rst_data",  bus1.dump_data, 32'd0);
    chk("rst_rd1",   bus1.rd1, 32'd0);
    #9 rst_n = 1'b1;

    tick();
    bus1.we = 1'b1; bus1.wa = 5'd5; bus1.wd = 32'hDEADBEEF;
    tick();
    bus1.we = 1'b0; bus1.ra1 = 5'd5; bus1.ra2 = 5'd0;
    #1;
    chk("r5_rd1_byp",   bus1.rd1, 32'hDEADBEEF);
    chk("r5_rd1_nobyp", bus0.rd1, 32'hDEADBEEF);
    chk("r0_rd2",       bus1.rd2, 32'd0);

    bus1.we = 1'b1; bus1.wa = 5'd0; bus1.wd = 32'h12345678;
    bus1.ra1 = 5'd0; bus1.ra2 = 5'd5;
    #1;
    chk("r0_no_bypass_fwd", bus1.rd1, 32'd0);
    tick();
    bus1.we = 1'b0;
    #1;
    chk("r0_after_write", bus1.rd1, 32'd0);
    chk("r5_untouched",   bus0.rd2, 32'hDEADBEEF);

    bus1.we = 1'b1; bus1.wa = 5'd7; bus1.wd = 32'hA5A5A5A5; bus1.ra1 = 5'd7;
    #1;
    chk("bypass_same_cycle",   bus1.rd1, 32'hA5A5A5A5);
    chk("nobypass_same_cycle", bus0.rd1, 32'd0);
    tick();
    bus1.we = 1'b0;
    #1;
    chk("bypass_next_cycle",   bus1.rd1, 32'hA5A5A5A5);
    chk("nobypass_next_cycle", bus0.rd1, 32'hA5A5A5A5);

    for (int i = 1; i < 32; i++) begin
      bus1.we = 1'b1; bus1.wa = 5'(i); bus1.wd = i * 32'h01010101;
      tick();
    end
    bus1.we = 1'b0; bus1.ra1 = 5'd31; bus1.ra2 = 5'd16;
    #1;
    chk("load_r31", bus1.rd1, 32'h1F1F1F1F);
    chk("load_r16", bus0.rd2, 32'h10101010);

    bus1.dump_ready = 1'b1;
    bus1.dump_start = 1'b1;
    beats = 0;
    done_at = -1;
    for (int n = 1; n <= 40 && done_at < 0; n++) begin
      tick();
      bus1.dump_start = (n == 10);
      #1;
      if (bus1.dump_valid) begin
        chk("beat_idx",  {27'd0, bus1.dump_idx}, beats);
        chk("beat_data", bus1.dump_data, beats * 32'h01010101);
        beats++;
      end
      if (bus1.dump_done) done_at = n;
    end
    bus1.dump_start = 1'b0;
    chk("beat_count", beats, 32'd32);
    chk("done_cycle", done_at, 32'd33);
    tick();
    #1;
    chk("done_one_cycle", {31'd0, bus1.dump_done},  32'd0);
    chk("idle_after",     {31'd0, bus1.dump_valid}, 32'd0);

    bus1.dump_start = 1'b1;
    tick();
    bus1.dump_start = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("bp_idx3", {27'd0, bus1.dump_idx}, 32'd3);
    bus1.dump_ready = 1'b0;
    bus1.we = 1'b1; bus1.wa = 5'd3; bus1.wd = 32'hFFFF0000;
    tick();
    bus1.wa = 5'd4; bus1.wd = 32'h0BADF00D;
    tick();
    bus1.we = 1'b0; bus1.ra1 = 5'd3;
    tick();
    #1;
    chk("bp_hold_valid", {31'd0, bus1.dump_valid}, 32'd1);
    chk("bp_hold_idx",   {27'd0, bus1.dump_idx}, 32'd3);
    chk("bp_hold_data",  bus1.dump_data, 32'h03030303);
    chk("bp_r3_new",     bus1.rd1, 32'hFFFF0000);
    bus1.dump_ready = 1'b1;
    tick();
    #1;
    chk("bp_beat4_idx",  {27'd0, bus1.dump_idx}, 32'd4);
    chk("bp_beat4_data", bus1.dump_data, 32'h0BADF00D);
    for (int n = 0; n < 6; n++) tick();
    #1;
    chk("abort_at_idx10", {27'd0, bus1.dump_idx}, 32'd10);

    rst_n = 1'b0;
    bus1.ra2 = 5'd4;
    #1;
    chk("abort_valid",  {31'd0, bus1.dump_valid}, 32'd0);
    chk("abort_busy",   {31'd0, bus1.dump_busy},  32'd0);
    chk("abort_idx",    {27'd0, bus1.dump_idx},   32'd0);
    chk("abort_r3",     bus1.rd1, 32'd0);
    chk("abort_r4",     bus0.rd2, 32'd0);
    #3 rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      #1;
      chk("post_abort_done",  {31'd0, bus1.dump_done},  32'd0);
      chk("post_abort_valid", {31'd0, bus1.dump_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regbank32.md
# regbank32

General-purpose register bank of the MIPS datapath: 32 registers of WIDTH bits, one synchronous write port and two combinational read ports. The read ports drive the per-bit 32:1 read-select muxes that produce rs/rt operands for the decode stage. The bank also provides a handshaked debug dump port that streams all 32 registers, in index order, to the test/debug controller.

## Interface
- WIDTH, 32: register width in bits.
- BYPASS, 1: when 1, a same-cycle write is forwarded to the read ports (write-through); when 0, reads return the stored value.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- wa  in  5  write address.
- wd  in  WIDTH  write data.
- ra1  in  5  read address, port 1.
- ra2  in  5  read address, port 2.
- rd1  out  WIDTH  read data, port 1 (combinational).
- rd2  out  WIDTH  read data, port 2 (combinational).
- dump_start  in  1  request a full register dump; sampled only in IDLE.
- dump_valid  out  1  dump_idx/dump_data hold a valid beat.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  5  register index of the current beat.
- dump_data  out  WIDTH  register contents of the current beat.
- dump_busy  out  1  dump in progress (SEND state).
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Register 0 is hardwired to zero: writes to wa=0 are discarded; reads of address 0 return 0 regardless of BYPASS.
- Write: on the rising edge with we=1 and wa!=0, reg[wa] <= wd.
- Read: rdN = reg[raN]. With BYPASS=1, if we=1, wa==raN and wa!=0, rdN = wd in the same cycle. Both ports may read the same address.
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: dump_start=1 -> SEND; dump_idx <= 0, dump_data <= 0 (reg 0), dump_valid <= 1.
  - SEND: dump_valid=1, dump_busy=1. Beat is accepted when dump_valid && dump_ready. On accept with dump_idx<31: dump_idx <= dump_idx+1, dump_data <= reg[dump_idx+1] (array value before that edge's write), stay in SEND. On accept with dump_idx==31: dump_valid <= 0 -> DONE.
  - DONE: dump_done=1 for exactly one cycle -> IDLE.
- dump_start is ignored in SEND and DONE; no queuing.
- Normal writes continue during a dump. A beat already presented is a snapshot: dump_data does not change while dump_valid && !dump_ready, even if that register is written.

## Timing
- Reset (rst_n=0, asynchronous): all 32 registers = 0; FSM = IDLE; dump_valid=0, dump_busy=0, dump_done=0, dump_idx=0, dump_data=0. rd1/rd2 therefore read 0.
- Reset asserted mid-dump aborts immediately to the reset state; no dump_done pulse.
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Dump: first beat valid 1 cycle after dump_start; with dump_ready held high, one beat per cycle. Total is 32 beats, followed by dump_done in the cycle after the last accept. From start to done is 33 cycles minimum.
- dump_idx and dump_data are registered outputs. dump_busy and dump_done decode directly from state flops.

## Test plan
- Reset, then write 0xDEADBEEF to r5. Next cycle set ra1=5 and ra2=0 -> rd1=0xDEADBEEF, rd2=0.
- Write wd=0x12345678 to wa=0 -> r0 still reads 0; no other register changes.
- BYPASS=1: we=1, wa=7, wd=0xA5A5A5A5, ra1=7 in the same cycle -> rd1=0xA5A5A5A5 combinationally. BYPASS=0: rd1 shows the old value until the next cycle.
- Load reg[i]=i*0x01010101, pulse dump_start, hold dump_ready=1 -> 32 consecutive beats with idx 0..31 and data 0, 0x01010101, …, 0x1F1F1F1F; dump_done=1 exactly one cycle later; dump_start during SEND is ignored.
- Dump backpressure: hold dump_ready=0 at idx=3 and write r3=0xFFFF0000 -> dump_data stays at the old r3 value until accepted. Write r4=0x0BADF00D before idx 4 is loaded -> beat 4 carries 0x0BADF00D.
- Assert rst_n=0 at idx=10 -> dump_valid=0 and all registers=0 asynchronously; after release, no dump_done pulse and FSM in IDLE.
